// File: rtl/mux_scan_pkg.sv
// ============================================================================
// Module      : mux_scan_pkg
// Description : Shared types and default constants for the mux scan sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mux_scan_pkg;

    localparam int c_num_ch  = 31;
    localparam int c_sel_w   = 5;
    localparam int c_data_w  = 2;
    localparam int c_cnt_w   = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/mux_scan_ctrl_if.sv
// ============================================================================
// Module      : mux_scan_ctrl_if
// Description : Control, mux feedback and result bundle of the scan sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mux_scan_ctrl_if
    import mux_scan_pkg::*;
#(
    parameter int NUM_CH = c_num_ch,
    parameter int SEL_W  = c_sel_w,
    parameter int DATA_W = c_data_w
);
    logic              start;
    logic [NUM_CH-1:0] ch_mask;
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] mux_out;
    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_data;
    logic [SEL_W-1:0]  res_ch;
    logic              busy;
    logic              done;

    // master: the controlling agent (software side plus the mux itself)
    modport master (
        output start, ch_mask, mux_out, res_ready,
        input  sel, res_valid, res_data, res_ch, busy, done
    );

    modport slave (
        input  start, ch_mask, mux_out, res_ready,
        output sel, res_valid, res_data, res_ch, busy, done
    );
endinterface

`default_nettype wire

// File: rtl/mux_scan_next_ch.sv
// ============================================================================
// Module      : mux_scan_next_ch
// Description : Priority finder: lowest set mask bit and next set bit above i_cur.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_scan_next_ch
    import mux_scan_pkg::*;
#(
    parameter int NUM_CH = c_num_ch,
    parameter int SEL_W  = c_sel_w
) (
    input  wire logic [NUM_CH-1:0] i_mask,
    input  wire logic [SEL_W-1:0]  i_cur,
    output logic      [SEL_W-1:0]  o_next,
    output logic                   o_found,
    output logic      [SEL_W-1:0]  o_low
);

    // Walk downward so the last hit written is the lowest qualifying index.
    always_comb begin
        o_next  = '0;
        o_found = 1'b0;
        o_low   = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (i_mask[i]) begin
                o_low = SEL_W'(i);
                if (i > int'(i_cur)) begin
                    o_next  = SEL_W'(i);
                    o_found = 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mux_scan_ctrl.sv
// ============================================================================
// Module      : mux_scan_ctrl
// Description : Steps the mux select over enabled channels, settles, samples
//               and hands each sample out on a valid/ready result port.
//               Optional continuous scan: define MUX_SCAN_CONT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int NUM_CH     = c_num_ch,
    parameter int SEL_W      = c_sel_w,
    parameter int DATA_W     = c_data_w,
    parameter int SETTLE_CYC = 1
) (
    input  wire logic         clk,
    input  wire logic         reset,
    mux_scan_ctrl_if.slave    bus
);

    localparam logic [c_cnt_w-1:0] c_settle_init = c_cnt_w'(SETTLE_CYC - 1);

    state_t              r_state;
    logic [NUM_CH-1:0]   r_mask;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [SEL_W-1:0]    r_sel;
    logic                r_res_valid;
    logic [DATA_W-1:0]   r_res_data;
    logic [SEL_W-1:0]    r_res_ch;
    logic                r_done;

    state_t              w_state_nx;
    logic [NUM_CH-1:0]   w_mask_nx;
    logic [c_cnt_w-1:0]  w_cnt_nx;
    logic [SEL_W-1:0]    w_sel_nx;
    logic                w_valid_nx;
    logic [DATA_W-1:0]   w_data_nx;
    logic [SEL_W-1:0]    w_ch_nx;
    logic                w_done_nx;
    logic                w_hs;

    logic [NUM_CH-1:0]   w_find_mask;
    logic [SEL_W-1:0]    w_next;
    logic                w_found;
    logic [SEL_W-1:0]    w_low;

    // In IDLE the first channel must come from the incoming mask, not the latched one.
    assign w_find_mask = (r_state == ST_IDLE) ? bus.ch_mask : r_mask;

    mux_scan_next_ch #(
        .NUM_CH (NUM_CH),
        .SEL_W  (SEL_W)
    ) u_next_ch (
        .i_mask  (w_find_mask),
        .i_cur   (r_sel),
        .o_next  (w_next),
        .o_found (w_found),
        .o_low   (w_low)
    );

    assign w_hs = r_res_valid && bus.res_ready;

`ifdef MUX_SCAN_CONT_EN
    logic r_stop;
    logic w_stop_nx;
`endif

    always_comb begin
        w_state_nx = r_state;
        w_mask_nx  = r_mask;
        w_cnt_nx   = r_cnt;
        w_sel_nx   = r_sel;
        w_valid_nx = r_res_valid;
        w_data_nx  = r_res_data;
        w_ch_nx    = r_res_ch;
        w_done_nx  = 1'b0;
`ifdef MUX_SCAN_CONT_EN
        w_stop_nx  = r_stop;
`endif
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    if (|bus.ch_mask) begin
                        w_mask_nx  = bus.ch_mask;
                        w_sel_nx   = w_low;
                        w_cnt_nx   = c_settle_init;
                        w_state_nx = ST_SETTLE;
                    end else begin
                        w_state_nx = ST_DONE;
                        w_done_nx  = 1'b1;
                    end
                end
            end
            ST_SETTLE: begin
                if (r_cnt == '0) begin
                    w_data_nx  = bus.mux_out;
                    w_ch_nx    = r_sel;
                    w_valid_nx = 1'b1;
                    w_state_nx = ST_HOLD;
                end else begin
                    w_cnt_nx = r_cnt - 1'b1;
                end
            end
            ST_HOLD: begin
                if (w_hs) begin
                    w_valid_nx = 1'b0;
`ifdef MUX_SCAN_CONT_EN
                    if (r_stop || bus.start) begin
                        w_state_nx = ST_IDLE;
                    end else if (w_found) begin
                        w_sel_nx   = w_next;
                        w_cnt_nx   = c_settle_init;
                        w_state_nx = ST_SETTLE;
                    end else begin
                        // End of a pass: wrap and flag the completed pass.
                        w_sel_nx   = w_low;
                        w_cnt_nx   = c_settle_init;
                        w_state_nx = ST_SETTLE;
                        w_done_nx  = 1'b1;
                    end
`else
                    if (w_found) begin
                        w_sel_nx   = w_next;
                        w_cnt_nx   = c_settle_init;
                        w_state_nx = ST_SETTLE;
                    end else begin
                        w_state_nx = ST_DONE;
                        w_done_nx  = 1'b1;
                    end
`endif
                end
            end
            ST_DONE: begin
                w_state_nx = ST_IDLE;
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
`ifdef MUX_SCAN_CONT_EN
        if (w_state_nx == ST_IDLE) begin
            w_stop_nx = 1'b0;
        end else if (r_state != ST_IDLE && bus.start) begin
            w_stop_nx = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_mask      <= '0;
            r_cnt       <= '0;
            r_sel       <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_ch    <= '0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_mask      <= w_mask_nx;
            r_cnt       <= w_cnt_nx;
            r_sel       <= w_sel_nx;
            r_res_valid <= w_valid_nx;
            r_res_data  <= w_data_nx;
            r_res_ch    <= w_ch_nx;
            r_done      <= w_done_nx;
        end
    end

`ifdef MUX_SCAN_CONT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stop <= 1'b0;
        end else begin
            r_stop <= w_stop_nx;
        end
    end
`endif

    assign bus.sel       = r_sel;
    assign bus.res_valid = r_res_valid;
    assign bus.res_data  = r_res_data;
    assign bus.res_ch    = r_res_ch;
    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.done      = r_done;

endmodule

`default_nettype wire
